// File: rtl/thermal_shutdown_ctrl.sv
// thermal_shutdown_ctrl: debounced CPU over-temperature shutdown sequencer with cooldown and retry lockout
module thermal_shutdown_ctrl #(
  parameter int DEBOUNCE  = 4,
  parameter int COOLDOWN  = 16,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8,
  parameter int RETRY_W   = 2
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               cpu_overheated,
  input  logic               clear_lockout,
  output logic               shut_off_computer,
  output logic               warning,
  output logic               locked_out,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);
  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_DEB  = 3'd1,
    S_SHUT = 3'd2,
    S_COOL = 3'd3,
    S_LOCK = 3'd4
  } state_e;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               shut_q, warn_q, lock_q;
  logic               retry_sat;
  assign retry_sat = retry_q == {RETRY_W{1'b1}};
  // next-state, counter and retry bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      S_RUN: begin
        if (clear_lockout) retry_d = '0;
        if (cpu_overheated) begin
          state_d = S_DEB;
          cnt_d   = CNT_W'(1);
        end
      end
      S_DEB: begin
        if (!cpu_overheated) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
          state_d = S_SHUT;
          retry_d = retry_sat ? retry_q : retry_q + RETRY_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHUT: begin
        if (!cpu_overheated) begin
          state_d = (retry_q >= RETRY_W'(MAX_RETRY)) ? S_LOCK : S_COOL;
          cnt_d   = '0;
        end
      end
      S_COOL: begin
        if (cpu_overheated) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(COOLDOWN - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOCK: begin
        if (clear_lockout && !cpu_overheated) begin
          state_d = S_RUN;
          retry_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end
  // state registers with Moore outputs registered from the next state
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      retry_q <= '0;
      shut_q  <= 1'b0;
      warn_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      shut_q  <= state_d inside {S_SHUT, S_COOL, S_LOCK};
      warn_q  <= state_d == S_DEB;
      lock_q  <= state_d == S_LOCK;
    end
  end
  assign shut_off_computer = shut_q;
  assign warning           = warn_q;
  assign locked_out        = lock_q;
  assign retry_cnt         = retry_q;
  assign state             = state_q;
endmodule

// File: tb/tb_thermal_shutdown_ctrl.sv
// tb_thermal_shutdown_ctrl: scoreboard bench comparing the controller against a cycle model
module tb_thermal_shutdown_ctrl;
  localparam int DEB  = 4;
  localparam int COOL = 16;
  localparam int MAXR = 3;
  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       cpu_overheated = 1'b0;
  logic       clear_lockout = 1'b0;
  logic       shut_off_computer, warning, locked_out;
  logic [1:0] retry_cnt;
  logic [2:0] state;
  logic [7:0] obs;
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_state = 0;
  int m_cnt = 0;
  int m_retry = 0;
  thermal_shutdown_ctrl dut (
    .clk(clk),
    .areset_n(areset_n),
    .cpu_overheated(cpu_overheated),
    .clear_lockout(clear_lockout),
    .shut_off_computer(shut_off_computer),
    .warning(warning),
    .locked_out(locked_out),
    .retry_cnt(retry_cnt),
    .state(state)
  );
  always #5 clk = ~clk;
  assign obs = {state, retry_cnt, shut_off_computer, warning, locked_out};
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] m_out();
    logic [2:0] s;
    logic [1:0] r;
    s = 3'(m_state);
    r = 2'(m_retry);
    return {s, r, m_state >= 2 && m_state <= 4, m_state == 1, m_state == 4};
  endfunction
  task automatic model(input logic oh, input logic clr);
    case (m_state)
      0: begin
        if (clr) m_retry = 0;
        if (oh) begin m_state = 1; m_cnt = 1; end
      end
      1: begin
        if (!oh) begin m_state = 0; m_cnt = 0; end
        else if (m_cnt == DEB - 1) begin m_state = 2; if (m_retry < 3) m_retry++; end
        else m_cnt++;
      end
      2: if (!oh) begin m_state = (m_retry >= MAXR) ? 4 : 3; m_cnt = 0; end
      3: begin
        if (oh) m_cnt = 0;
        else if (m_cnt == COOL - 1) begin m_state = 0; m_cnt = 0; end
        else m_cnt++;
      end
      default: if (clr && !oh) begin m_state = 0; m_retry = 0; m_cnt = 0; end
    endcase
  endtask
  task automatic cyc(input logic oh, input logic clr, input string tag, input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_overheated = oh;
      clear_lockout = clr;
      model(oh, clr);
      exp_q.push_back(m_out());
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) chk({tag, "_underflow"}, obs, 8'h00);
      else chk(tag, obs, exp_q.pop_front());
    end
  endtask
  initial begin
    #1 chk("reset_async", obs, 8'h00);
    repeat (2) @(posedge clk);
    #1 chk("reset_held", obs, 8'h00);
    @(negedge clk);
    areset_n = 1'b1;
    cyc(0, 0, "idle", 10);
    cyc(1, 0, "glitch_hi", 3);
    cyc(0, 0, "glitch_lo", 3);
    cyc(1, 0, "evt1_deb", 4);
    cyc(1, 1, "evt1_shut_clr", 2);
    cyc(0, 0, "evt1_cool", 17);
    cyc(1, 0, "evt2_deb", 4);
    cyc(0, 0, "evt2_cool10", 11);
    cyc(1, 0, "evt2_reheat");
    cyc(0, 0, "evt2_recool", 17);
    cyc(1, 0, "evt3_deb", 5);
    cyc(0, 0, "evt3_lock", 2);
    cyc(1, 1, "lock_clr_hot", 2);
    cyc(0, 0, "lock_hold");
    cyc(0, 1, "lock_clr");
    cyc(0, 0, "post_clr", 2);
    cyc(1, 0, "evt4_deb", 4);
    cyc(0, 0, "evt4_cool", 17);
    cyc(1, 1, "run_clr_hot");
    cyc(0, 0, "run_back", 2);
    cyc(1, 0, "evt5_deb", 4);
    cyc(0, 0, "evt5_cool", 5);
    #2 areset_n = 1'b0;
    #1 chk("async_mid_cool", obs, 8'h00);
    m_state = 0;
    m_cnt = 0;
    m_retry = 0;
    @(negedge clk);
    areset_n = 1'b1;
    cyc(0, 0, "after_rst", 3);
    cyc(1, 0, "final_deb", 2);
    cyc(0, 0, "final_idle", 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
